// File: rtl/uart_cmd_ctrl.sv
// UART command decoder: turns 4-byte SYNC/ADDR/DATA/CHK frames into single-cycle
// register writes. Rejected or timed-out frames raise frame_err and bump err_count.
module uart_cmd_ctrl #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       reg_wr,
  output logic [1:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] err_count,
  output logic [1:0] dbg_state_o
);

  // Handshake: rx_valid is a one-cycle strobe with no backpressure; every strobe
  // is consumed in the cycle it appears, whatever state the decoder is in.
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] GET_ADDR = 2'd1;
  localparam logic [1:0] GET_DATA = 2'd2;
  localparam logic [1:0] GET_CHK  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        reg_wr_q, reg_wr_d;
  logic [1:0]  reg_addr_q, reg_addr_d;
  logic [7:0]  reg_wdata_q, reg_wdata_d;
  logic        frame_err_q, frame_err_d;
  logic        busy_q, busy_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        timeout_hit;

  // An arriving byte always beats the timeout in the same cycle.
  assign timeout_hit = (state_q != IDLE) && !rx_valid && (cnt_q == TIMEOUT_CYC - 16'd1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    reg_wr_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    frame_err_d = 1'b0;

    if (state_q == IDLE) begin
      cnt_d = 16'd0;
      if (rx_valid && (rx_byte == SYNC_BYTE)) begin
        state_d = GET_ADDR;
      end
    end else if (rx_valid) begin
      cnt_d = 16'd0;
      case (state_q)
        GET_ADDR: begin
          addr_d  = rx_byte;
          state_d = GET_DATA;
        end
        GET_DATA: begin
          data_d  = rx_byte;
          state_d = GET_CHK;
        end
        default: begin
          state_d = IDLE;
          if ((rx_byte == (addr_q ^ data_q)) && (addr_q[7:2] == 6'd0)) begin
            reg_wr_d    = 1'b1;
            reg_addr_d  = addr_q[1:0];
            reg_wdata_d = data_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      endcase
    end else if (timeout_hit) begin
      state_d     = IDLE;
      cnt_d       = 16'd0;
      frame_err_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end

    busy_d    = (state_d != IDLE);
    err_cnt_d = (frame_err_d && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 16'd0;
      addr_q      <= 8'd0;
      data_q      <= 8'd0;
      reg_wr_q    <= 1'b0;
      reg_addr_q  <= 2'd0;
      reg_wdata_q <= 8'd0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      reg_wr_q    <= reg_wr_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign reg_wr      = reg_wr_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wdata   = reg_wdata_q;
  assign frame_err   = frame_err_q;
  assign busy        = busy_q;
  assign err_count   = err_cnt_q;
  assign dbg_state_o = state_q;

endmodule
